// File: rtl/beep_pattern_gen_pkg.sv
// Shared definitions for the beep pattern generator: state encoding and
// default field widths.
package beep_pattern_gen_pkg;

  localparam int CNT_W_DEF  = 28;
  localparam int NUM_W_DEF  = 8;
  localparam int TONE_W_DEF = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ON   = 2'd1,
    ST_OFF  = 2'd2
  } state_e;

endpackage

// File: rtl/beep_pattern_gen_if.sv
// Control/status bundle between board-level control logic (master) and the
// beep pattern generator (slave).
interface beep_pattern_gen_if
  import beep_pattern_gen_pkg::*;
#(
  parameter int CNT_W  = CNT_W_DEF,
  parameter int NUM_W  = NUM_W_DEF,
  parameter int TONE_W = TONE_W_DEF
) ();

  logic              start;
  logic              stop;
  logic              repeat_en;
  logic [NUM_W-1:0]  beep_num;
  logic [CNT_W-1:0]  on_cycles;
  logic [CNT_W-1:0]  off_cycles;
  logic [TONE_W-1:0] tone_half;
  logic              beep;
  logic              busy;
  logic              done;

  modport master (
    output start, stop, repeat_en, beep_num, on_cycles, off_cycles, tone_half,
    input  beep, busy, done
  );

  modport slave (
    input  start, stop, repeat_en, beep_num, on_cycles, off_cycles, tone_half,
    output beep, busy, done
  );

endinterface

// File: rtl/beep_tone_div.sv
// Square-wave divider for ON-phase tone modulation. The output is low while
// disabled, high on the first enabled cycle after clear, and toggles every
// `half` cycles afterwards; half==0 holds the output high (DC drive).
module beep_tone_div #(
  parameter int TONE_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              enable,
  input  logic [TONE_W-1:0] half,
  output logic              wave
);

  logic [TONE_W-1:0] cnt_q, cnt_d;
  logic              wave_q, wave_d;

  // Next tone counter / wave level; clear and enable describe the coming cycle.
  always_comb begin
    cnt_d  = cnt_q;
    wave_d = wave_q;
    if (!enable) begin
      cnt_d  = '0;
      wave_d = 1'b0;
    end else if (clear || (half == '0)) begin
      cnt_d  = '0;
      wave_d = 1'b1;
    end else if (cnt_q == (half - TONE_W'(1))) begin
      cnt_d  = '0;
      wave_d = ~wave_q;
    end else begin
      cnt_d  = cnt_q + TONE_W'(1);
      wave_d = wave_q;
    end
  end

  // Tone state registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      wave_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      wave_q <= wave_d;
    end
  end

  assign wave = wave_q;

endmodule

// File: rtl/beep_pattern_gen.sv
// Buzzer burst generator: plays beep_num beeps of on_cycles ON and
// off_cycles OFF, optionally looping and optionally tone-modulated.
module beep_pattern_gen
  import beep_pattern_gen_pkg::*;
#(
  parameter int CNT_W  = CNT_W_DEF,
  parameter int NUM_W  = NUM_W_DEF,
  parameter int TONE_W = TONE_W_DEF
) (
  input logic               clk,
  input logic               rst_n,
  beep_pattern_gen_if.slave bus
);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  phase_q, phase_d;
  logic [NUM_W-1:0]  bcnt_q, bcnt_d;
  logic [NUM_W-1:0]  num_q, num_d;
  logic [CNT_W-1:0]  on_last_q, on_last_d;   // ON length minus one
  logic [CNT_W-1:0]  off_len_q, off_len_d;   // 0 means no OFF phase
  logic [TONE_W-1:0] tone_q, tone_d;
  logic              rep_q, rep_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic              beep_end_s;    // a whole beep (ON + OFF) finishes this cycle
  logic              last_beep_s;
  logic              tone_clear_s;  // next cycle is the first cycle of an ON phase
  logic              tone_en_s;
  logic              tone_wave_s;

  assign last_beep_s = (bcnt_q == (num_q - NUM_W'(1)));
  assign tone_en_s   = (state_d == ST_ON);

  // Next-state, counter and shadow-configuration logic; stop beats phase ends.
  always_comb begin
    state_d      = state_q;
    phase_d      = phase_q;
    bcnt_d       = bcnt_q;
    num_d        = num_q;
    on_last_d    = on_last_q;
    off_len_d    = off_len_q;
    tone_d       = tone_q;
    rep_d        = rep_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    beep_end_s   = 1'b0;
    tone_clear_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        busy_d  = 1'b0;
        phase_d = '0;
        bcnt_d  = '0;
        if (bus.start && (bus.beep_num == '0)) begin
          done_d = 1'b1;
        end else if (bus.start) begin
          num_d        = bus.beep_num;
          on_last_d    = (bus.on_cycles == '0) ? '0 : (bus.on_cycles - CNT_W'(1));
          off_len_d    = bus.off_cycles;
          tone_d       = bus.tone_half;
          rep_d        = bus.repeat_en;
          state_d      = ST_ON;
          busy_d       = 1'b1;
          tone_clear_s = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ON: begin
        if (bus.stop) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
          phase_d = '0;
          bcnt_d  = '0;
        end else if (phase_q == on_last_q) begin
          phase_d = '0;
          if (off_len_q == '0) begin
            beep_end_s = 1'b1;
          end else begin
            state_d = ST_OFF;
          end
        end else begin
          phase_d = phase_q + CNT_W'(1);
        end
      end
      ST_OFF: begin
        if (bus.stop) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
          phase_d = '0;
          bcnt_d  = '0;
        end else if (phase_q == (off_len_q - CNT_W'(1))) begin
          phase_d    = '0;
          beep_end_s = 1'b1;
        end else begin
          phase_d = phase_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
        phase_d = '0;
        bcnt_d  = '0;
      end
    endcase

    if (beep_end_s && !last_beep_s) begin
      bcnt_d       = bcnt_q + NUM_W'(1);
      state_d      = ST_ON;
      tone_clear_s = 1'b1;
    end else if (beep_end_s && rep_q) begin
      bcnt_d       = '0;
      state_d      = ST_ON;
      tone_clear_s = 1'b1;
    end else if (beep_end_s) begin
      bcnt_d  = '0;
      state_d = ST_IDLE;
      busy_d  = 1'b0;
      done_d  = 1'b1;
    end else begin
      // mid-phase: the values chosen by the state case stand
      tone_clear_s = tone_clear_s;
    end
  end

  // All FSM state, counters, shadow config and status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      phase_q   <= '0;
      bcnt_q    <= '0;
      num_q     <= '0;
      on_last_q <= '0;
      off_len_q <= '0;
      tone_q    <= '0;
      rep_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      bcnt_q    <= bcnt_d;
      num_q     <= num_d;
      on_last_q <= on_last_d;
      off_len_q <= off_len_d;
      tone_q    <= tone_d;
      rep_q     <= rep_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  beep_tone_div #(.TONE_W(TONE_W)) u_tone (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (tone_clear_s),
    .enable (tone_en_s),
    .half   (tone_q),
    .wave   (tone_wave_s)
  );

  assign bus.beep = tone_wave_s;
  assign bus.busy = busy_q;
  assign bus.done = done_q;

endmodule

// File: tb/tb_beep_pattern_gen.sv
// Randomised and directed bench for beep_pattern_gen against a cycle-indexed
// waveform model derived from the burst rules.
module tb_beep_pattern_gen;

  localparam int CNT_W  = 28;
  localparam int NUM_W  = 8;
  localparam int TONE_W = 16;

  logic clk;
  logic rst_n;

  beep_pattern_gen_if #(.CNT_W(CNT_W), .NUM_W(NUM_W), .TONE_W(TONE_W)) bus ();

  beep_pattern_gen #(.CNT_W(CNT_W), .NUM_W(NUM_W), .TONE_W(TONE_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total;
  int bad;

  // current scenario configuration (model view)
  int c_num, c_on, c_off, c_tone, c_stop;
  bit c_rep;

  logic [2:0] obs [0:63];   // {beep, busy, done} sampled in cycle t after start

  // Expected {beep, busy, done} in cycle t (start sampled at the edge ending cycle 0).
  function automatic logic [2:0] model(input int t);
    int on_len, per, tot, pos;
    logic b, bz, d;
    b = 1'b0; bz = 1'b0; d = 1'b0;
    on_len = (c_on == 0) ? 1 : c_on;
    per    = on_len + c_off;
    tot    = c_num * per;
    if (!(c_stop > 0 && t > c_stop)) begin
      if (c_num == 0) begin
        d = (t == 1);
      end else if (c_rep || t <= tot) begin
        bz  = 1'b1;
        pos = (t - 1) % per;
        b   = (pos < on_len) && ((c_tone == 0) || (((pos / c_tone) % 2) == 0));
      end else begin
        d = (t == tot + 1);
      end
    end
    return {b, bz, d};
  endfunction

  task automatic set_cfg(input int num, input int on, input int off, input int tone,
                         input bit rep, input int stp);
    c_num = num; c_on = on; c_off = off; c_tone = tone; c_rep = rep; c_stop = stp;
  endtask

  task automatic idle_inputs();
    bus.start = 1'b0; bus.stop = 1'b0; bus.repeat_en = 1'b0;
    bus.beep_num = '0; bus.on_cycles = '0; bus.off_cycles = '0; bus.tone_half = '0;
  endtask

  // Play one scenario and record outputs; extra starts at xs_a/xs_b, optional input scrambling.
  task automatic run_burst(input int ncyc, input int xs_a, input int xs_b,
                           input bit scramble, input bit stop_with_start);
    logic [2:0] e;
    @(negedge clk);
    bus.beep_num   = NUM_W'(c_num);
    bus.on_cycles  = CNT_W'(c_on);
    bus.off_cycles = CNT_W'(c_off);
    bus.tone_half  = TONE_W'(c_tone);
    bus.repeat_en  = c_rep;
    bus.start      = 1'b1;
    bus.stop       = stop_with_start;
    for (int t = 1; t <= ncyc; t++) begin
      @(negedge clk);
      obs[t] = {bus.beep, bus.busy, bus.done};
      e = model(t);
      bus.stop = (c_stop == t);
      if (t == xs_a || t == xs_b) begin
        bus.start = 1'b1;
      end else begin
        bus.start = scramble && e[1] && ($urandom_range(0, 3) == 0);
      end
      if (scramble && e[1]) begin
        bus.beep_num   = NUM_W'($urandom_range(0, 5));
        bus.on_cycles  = CNT_W'($urandom_range(0, 7));
        bus.off_cycles = CNT_W'($urandom_range(0, 7));
        bus.tone_half  = TONE_W'($urandom_range(0, 4));
        bus.repeat_en  = $urandom_range(0, 1) == 1;
      end
    end
    idle_inputs();
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle_inputs();
    repeat (2) @(negedge clk);
    total++;
    if ({bus.beep, bus.busy, bus.done} !== 3'b000) begin
      bad++;
      $display("FAIL reset_hold got=%b required=000", {bus.beep, bus.busy, bus.done});
    end
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if ({bus.beep, bus.busy, bus.done} !== 3'b000) begin
      bad++;
      $display("FAIL reset_release got=%b required=000", {bus.beep, bus.busy, bus.done});
    end
  endtask

  task automatic test_directed();
    int ncyc;
    bit sws;
    logic [2:0] e;
    for (int i = 0; i < 10; i++) begin
      sws = 1'b0;
      case (i)
        0: begin set_cfg(2, 3, 2, 0, 1'b0, 0);  ncyc = 14; end
        1: begin set_cfg(1, 4, 1, 1, 1'b0, 0);  ncyc = 8;  end
        2: begin set_cfg(1, 4, 1, 2, 1'b0, 0);  ncyc = 8;  end
        3: begin set_cfg(1, 2, 2, 0, 1'b1, 22); ncyc = 26; end
        4: begin set_cfg(1, 2, 2, 0, 1'b1, 7);  ncyc = 14; end
        5: begin set_cfg(0, 3, 2, 0, 1'b0, 0);  ncyc = 4;  end
        6: begin set_cfg(3, 0, 0, 0, 1'b0, 0);  ncyc = 7;  end
        7: begin set_cfg(2, 2, 1, 3, 1'b0, 0);  ncyc = 9;  sws = 1'b1; end
        8: begin set_cfg(2, 3, 2, 0, 1'b0, 4);  ncyc = 8;  end
        default: begin set_cfg(2, 3, 2, 0, 1'b0, 3); ncyc = 7; end
      endcase
      run_burst(ncyc, 0, 0, 1'b0, sws);
      for (int t = 1; t <= ncyc; t++) begin
        e = model(t);
        total++;
        if (obs[t] !== e) begin
          bad++;
          $display("FAIL directed%0d t=%0d got beep/busy/done=%b required=%b", i, t, obs[t], e);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [2:0] e;
    set_cfg(2, 3, 2, 0, 1'b0, 0);
    run_burst(14, 2, 4, 1'b0, 1'b0);
    for (int t = 1; t <= 14; t++) begin
      e = model(t);
      total++;
      if (obs[t] !== e) begin
        bad++;
        $display("FAIL back_to_back t=%0d got beep/busy/done=%b required=%b", t, obs[t], e);
      end
    end
  endtask

  task automatic test_async_reset();
    set_cfg(3, 5, 2, 0, 1'b0, 0);
    @(negedge clk);
    bus.beep_num = NUM_W'(3); bus.on_cycles = CNT_W'(5); bus.off_cycles = CNT_W'(2);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    total++;
    if ({bus.beep, bus.busy, bus.done} !== 3'b110) begin
      bad++;
      $display("FAIL arst_pre got=%b required=110", {bus.beep, bus.busy, bus.done});
    end
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({bus.beep, bus.busy, bus.done} !== 3'b000) begin
      bad++;
      $display("FAIL arst_immediate got=%b required=000", {bus.beep, bus.busy, bus.done});
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if ({bus.beep, bus.busy, bus.done} !== 3'b000) begin
      bad++;
      $display("FAIL arst_after got=%b required=000", {bus.beep, bus.busy, bus.done});
    end
    bus.beep_num = NUM_W'(1); bus.on_cycles = CNT_W'(2); bus.off_cycles = CNT_W'(1);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    total++;
    if ({bus.beep, bus.busy, bus.done} !== 3'b110) begin
      bad++;
      $display("FAIL arst_restart got=%b required=110", {bus.beep, bus.busy, bus.done});
    end
    idle_inputs();
    repeat (6) @(negedge clk);
  endtask

  task automatic test_random();
    int ncyc, tot, on_len;
    logic [2:0] e;
    for (int it = 0; it < 30; it++) begin
      c_num  = $urandom_range(0, 4);
      c_on   = $urandom_range(0, 5);
      c_off  = $urandom_range(0, 4);
      c_tone = $urandom_range(0, 3);
      c_rep  = ($urandom_range(0, 3) == 0) && (c_num > 0);
      on_len = (c_on == 0) ? 1 : c_on;
      tot    = c_num * (on_len + c_off);
      if (c_rep) begin
        c_stop = $urandom_range(1, 20);
        ncyc   = c_stop + 3;
      end else begin
        c_stop = (tot > 0 && $urandom_range(0, 4) == 0) ? $urandom_range(1, tot) : 0;
        ncyc   = tot + 4;
      end
      run_burst(ncyc, 0, 0, 1'b1, 1'b0);
      for (int t = 1; t <= ncyc; t++) begin
        e = model(t);
        total++;
        if (obs[t] !== e) begin
          bad++;
          $display("FAIL random%0d t=%0d num=%0d on=%0d off=%0d tone=%0d rep=%0d stop=%0d got=%b required=%b",
                   it, t, c_num, c_on, c_off, c_tone, c_rep, c_stop, obs[t], e);
        end
      end
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_directed();
    test_back_to_back();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
